msrh_brtag_freelist: RTL and testbench
======================================

// Module: msrh_brtag_freelist
// PURPOSE
//  Allocates branch tags (brtag) to branches at dispatch, tracks the branch mask carried by every in-flight op, and recycles tags.
//  Tags are returned on commit via the cmt_brtag interface signals, or on mispredict recovery via the br_upd interface signals.
//  Sits between the dispatch stage and the BRU issue queue. It is the single owner of the brtag resource.
// PARAMETERS
//  BRTAG_SIZE  16  number of tags; equals msrh_conf_pkg::RV_BRU_ENTRY_SIZE
//  DISP_SIZE    4  dispatch/commit group width; equals msrh_conf_pkg::DISP_SIZE
//  Derived: TAG_W = $clog2(BRTAG_SIZE); CNT_W = $clog2(BRTAG_SIZE+1)
// PORTS
//  i_clk            in   1                  clock
//  i_reset          in   1                  asynchronous reset, active-high
//  i_disp_valid     in   1                  dispatch group presented
//  i_disp_is_br     in   DISP_SIZE          slot holds a branch needing a tag
//  o_disp_ready     out  1                  group can be accepted this cycle
//  o_disp_brtag     out  DISP_SIZE*TAG_W    tag assigned to each branch slot
//  o_disp_brmask    out  DISP_SIZE*BRTAG_SIZE  unresolved-branch mask each slot depends on
//  i_cmt_commit     in   1                  commit group valid
//  i_cmt_is_br      in   DISP_SIZE          committed slot is a branch
//  i_cmt_brtag      in   DISP_SIZE*TAG_W    tag of committed branch
//  i_br_upd_update  in   1                  BRU resolution valid
//  i_br_upd_mispredict in 1                 resolution was a mispredict
//  i_br_upd_dead    in   1                  resolved op already killed; ignore
//  i_br_upd_brtag   in   TAG_W              tag of resolving branch
//  i_flush          in   1                  commit-side pipeline flush
//  o_free_count     out  CNT_W              number of free tags
//  o_empty          out  1                  no tag allocated (free_count==BRTAG_SIZE)
// BEHAVIOUR
//  State
//   - valid[BRTAG_SIZE]
//   - resolved[BRTAG_SIZE]
//   - dep_mask[BRTAG_SIZE][BRTAG_SIZE]: the unresolved tags older than each tag
//  Reset
//   - All state cleared. o_free_count=BRTAG_SIZE, o_empty=1, o_disp_ready=1.
//   - o_disp_brtag=0, o_disp_brmask=0.
//  Live mask
//   - live = valid & ~resolved.
//  Dispatch grant
//   - o_disp_ready = (free_count >= popcount(i_disp_is_br)) & ~flush_now.
//   - flush_now = i_flush | (upd_ok & i_br_upd_mispredict).
//   - upd_ok = i_br_upd_update & ~i_br_upd_dead.
//  Allocation
//   - Fire = i_disp_valid & o_disp_ready. Acceptance is all-or-nothing per group.
//   - Branch slots, in ascending slot order, get the lowest-index free tags. Combinational, same cycle.
//   - o_disp_brmask[s] = live | tags assigned to branch slots < s in the same group.
//   - A branch's own tag is never in its own mask.
//   - On fire, the next edge sets valid, clears resolved, and loads dep_mask with the slot's mask.
//   - Non-branch slots: o_disp_brtag=0; brmask still valid.
//  Correct resolution (upd_ok & ~mispredict)
//   - resolved[tag]<=1.
//   - Bit tag is cleared in every dep_mask.
//   - The tag stays allocated until commit.
//  Mispredict (upd_ok & mispredict)
//   - Every tag t with dep_mask[t][tag]=1 is freed next edge (younger branches).
//   - The mispredicting tag itself is marked resolved, not freed.
//  Commit
//   - For each slot with i_cmt_commit & i_cmt_is_br, valid[i_cmt_brtag]<=0.
//   - Committing a non-valid tag is a bench assertion error.
//  Flush
//   - i_flush frees all tags next edge. It wins over the same-cycle allocation, which is suppressed via ready=0.
//  Recycle latency
//   - A tag freed at edge N is allocatable from cycle N+1. Same-cycle free+alloc never reuses it.
//  Simultaneous events
//   - Commit, resolution and allocation target disjoint tags. All apply in one edge.
//   - Commit of a tag being mispredict-freed: the result is free.
//  Outputs
//   - o_free_count and o_empty are registered from valid (popcount), updated every edge.
//   - Reset asserted mid-operation clears everything asynchronously. No partial state survives.
// TESTING
//  1. Reset; dispatch is_br=4'b1111 -> ready=1; brtags 0,1,2,3; brmask slot3=0x0007; free_count=12 next cycle.
//  2. Fill 16 tags; then is_br=4'b0001 -> ready=0. Commit tag 5 -> next cycle ready=1, brtag=5.
//  3. Tags 0..3 allocated in order; mispredict tag1 -> tags 2,3 freed, 0 and 1 kept, free_count=14.
//  4. Tag0 resolves correct -> next dispatch brmask excludes bit0; dep_mask of tag1 drops bit0; tag0 is still counted allocated.
//  5. Same cycle: commit tag0, dispatch 1 branch with free_count=0 -> ready=0; next cycle brtag=0.
//  6. i_flush with 10 tags live and dispatch valid -> ready=0, free_count=16 next cycle; assert reset mid-burst -> outputs zero immediately.

Source files
------------

// File: rtl/msrh_brtag_freelist.sv
// Branch tag free list: hands out the lowest free brtags to a dispatch group,
// tracks which unresolved branches each tag depends on, and recycles tags.
module msrh_brtag_freelist #(
    parameter  int BRTAG_SIZE = 16,
    parameter  int DISP_SIZE  = 4,
    localparam int TAG_W      = $clog2(BRTAG_SIZE),
    localparam int CNT_W      = $clog2(BRTAG_SIZE + 1)
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic                                  i_disp_valid,
    input  logic [DISP_SIZE-1:0]                  i_disp_is_br,
    output logic                                  o_disp_ready,
    output logic [DISP_SIZE-1:0][TAG_W-1:0]       o_disp_brtag,
    output logic [DISP_SIZE-1:0][BRTAG_SIZE-1:0]  o_disp_brmask,
    input  logic                                  i_cmt_commit,
    input  logic [DISP_SIZE-1:0]                  i_cmt_is_br,
    input  logic [DISP_SIZE-1:0][TAG_W-1:0]       i_cmt_brtag,
    input  logic                                  i_br_upd_update,
    input  logic                                  i_br_upd_mispredict,
    input  logic                                  i_br_upd_dead,
    input  logic [TAG_W-1:0]                      i_br_upd_brtag,
    input  logic                                  i_flush,
    output logic [CNT_W-1:0]                      o_free_count,
    output logic                                  o_empty
);

    typedef logic [BRTAG_SIZE-1:0] mask_t;

    mask_t                               valid_q, resolved_q;
    mask_t                               dep_q [BRTAG_SIZE];
    mask_t                               valid_n, resolved_n;
    mask_t                               dep_n [BRTAG_SIZE];
    mask_t                               live, avail, taken;
    logic [DISP_SIZE-1:0][BRTAG_SIZE-1:0] alloc_oh;
    logic [CNT_W-1:0]                    free_count_q, br_cnt;
    logic                                empty_q;
    logic                                upd_ok, flush_now, fire, found;

    function automatic logic [CNT_W-1:0] popcnt(input mask_t m);
        popcnt = '0;
        for (int i = 0; i < BRTAG_SIZE; i++)
            popcnt = popcnt + CNT_W'(m[i]);
    endfunction

    assign live         = valid_q & ~resolved_q;
    assign o_free_count = free_count_q;
    assign o_empty      = empty_q;

    always_comb begin : grant
        upd_ok    = i_br_upd_update & ~i_br_upd_dead;
        flush_now = i_flush | (upd_ok & i_br_upd_mispredict);
        br_cnt    = '0;
        for (int s = 0; s < DISP_SIZE; s++)
            br_cnt = br_cnt + CNT_W'(i_disp_is_br[s]);
        o_disp_ready = (free_count_q >= br_cnt) & ~flush_now;
        fire         = i_disp_valid & o_disp_ready;
    end

    // Each branch slot takes the lowest tag not already claimed by an earlier slot.
    always_comb begin : alloc
        avail         = ~valid_q;
        taken         = '0;
        found         = 1'b0;
        alloc_oh      = '0;
        o_disp_brtag  = '0;
        o_disp_brmask = '0;
        for (int s = 0; s < DISP_SIZE; s++) begin
            o_disp_brmask[s] = live | taken;
            if (i_disp_is_br[s]) begin
                found = 1'b0;
                for (int t = 0; t < BRTAG_SIZE; t++) begin
                    if (!found && avail[t]) begin
                        found           = 1'b1;
                        o_disp_brtag[s] = TAG_W'(t);
                        alloc_oh[s][t]  = 1'b1;
                    end
                end
                avail = avail & ~alloc_oh[s];
                taken = taken | alloc_oh[s];
            end
        end
    end

    always_comb begin : next_state
        valid_n    = valid_q;
        resolved_n = resolved_q;
        for (int t = 0; t < BRTAG_SIZE; t++)
            dep_n[t] = dep_q[t];

        if (i_cmt_commit) begin
            for (int s = 0; s < DISP_SIZE; s++)
                if (i_cmt_is_br[s]) valid_n[i_cmt_brtag[s]] = 1'b0;
        end

        // A mispredict kills every branch that was dispatched under it.
        if (upd_ok) begin
            resolved_n[i_br_upd_brtag] = 1'b1;
            if (i_br_upd_mispredict) begin
                for (int t = 0; t < BRTAG_SIZE; t++)
                    if (dep_q[t][i_br_upd_brtag]) valid_n[t] = 1'b0;
            end
        end

        if (fire) begin
            for (int s = 0; s < DISP_SIZE; s++)
                for (int t = 0; t < BRTAG_SIZE; t++)
                    if (alloc_oh[s][t]) begin
                        valid_n[t]    = 1'b1;
                        resolved_n[t] = 1'b0;
                        dep_n[t]      = o_disp_brmask[s];
                    end
        end

        // Applied after the load so a branch dispatched alongside the resolution sees it cleared.
        if (upd_ok && !i_br_upd_mispredict) begin
            for (int t = 0; t < BRTAG_SIZE; t++)
                dep_n[t][i_br_upd_brtag] = 1'b0;
        end

        if (i_flush) begin
            valid_n    = '0;
            resolved_n = '0;
            for (int t = 0; t < BRTAG_SIZE; t++)
                dep_n[t] = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q      <= '0;
            resolved_q   <= '0;
            for (int t = 0; t < BRTAG_SIZE; t++)
                dep_q[t] <= '0;
            free_count_q <= CNT_W'(BRTAG_SIZE);
            empty_q      <= 1'b1;
        end else begin
            valid_q      <= valid_n;
            resolved_q   <= resolved_n;
            for (int t = 0; t < BRTAG_SIZE; t++)
                dep_q[t] <= dep_n[t];
            free_count_q <= CNT_W'(BRTAG_SIZE) - popcnt(valid_n);
            empty_q      <= (valid_n == '0);
        end
    end

endmodule

// File: tb/tb_msrh_brtag_freelist.sv
// Bench for msrh_brtag_freelist: directed scenarios with literal expectations,
// then a randomized run checked every cycle against an age-ordered tag model.
module tb_msrh_brtag_freelist;
    localparam int BS = 16;
    localparam int DS = 4;
    localparam int TW = 4;
    localparam int CW = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  disp_valid;
    logic [DS-1:0]         disp_is_br;
    logic                  disp_ready;
    logic [DS-1:0][TW-1:0] disp_brtag;
    logic [DS-1:0][BS-1:0] disp_brmask;
    logic                  cmt_commit;
    logic [DS-1:0]         cmt_is_br;
    logic [DS-1:0][TW-1:0] cmt_brtag;
    logic                  upd, misp, dead;
    logic [TW-1:0]         upd_tag;
    logic                  flush;
    logic [CW-1:0]         free_count;
    logic                  empty;

    always #5 clk = ~clk;

    msrh_brtag_freelist #(.BRTAG_SIZE(BS), .DISP_SIZE(DS)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_disp_valid(disp_valid), .i_disp_is_br(disp_is_br),
        .o_disp_ready(disp_ready), .o_disp_brtag(disp_brtag), .o_disp_brmask(disp_brmask),
        .i_cmt_commit(cmt_commit), .i_cmt_is_br(cmt_is_br), .i_cmt_brtag(cmt_brtag),
        .i_br_upd_update(upd), .i_br_upd_mispredict(misp), .i_br_upd_dead(dead),
        .i_br_upd_brtag(upd_tag), .i_flush(flush),
        .o_free_count(free_count), .o_empty(empty)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Model: a tag is either free or allocated with an age stamp; a mispredict
    // frees every allocated tag stamped later than the mispredicting one.
    bit m_valid [BS];
    bit m_res   [BS];
    int m_seq   [BS];
    int seq_ctr;
    int e_tag   [DS];
    logic [BS-1:0] e_mask [DS];
    bit e_ready, e_enough;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int t = 0; t < BS; t++) begin
            m_valid[t] = 0; m_res[t] = 0; m_seq[t] = 0;
        end
        seq_ctr = 0;
    endtask

    function automatic int free_cnt();
        int n = 0;
        for (int t = 0; t < BS; t++) if (!m_valid[t]) n++;
        return n;
    endfunction

    task automatic compute_expect();
        bit used [BS];
        logic [BS-1:0] live, extra;
        int nbr = 0;
        live = '0; extra = '0;
        for (int t = 0; t < BS; t++) begin
            used[t] = m_valid[t];
            live[t] = m_valid[t] && !m_res[t];
        end
        for (int s = 0; s < DS; s++) begin
            e_tag[s] = 0;
            e_mask[s] = live | extra;
            if (disp_is_br[s]) begin
                nbr++;
                for (int t = 0; t < BS; t++)
                    if (!used[t]) begin e_tag[s] = t; used[t] = 1; extra[t] = 1'b1; break; end
            end
        end
        e_enough = free_cnt() >= nbr;
        e_ready  = e_enough && !(flush || (upd && !dead && misp));
    endtask

    task automatic compare_model();
        compute_expect();
        check("ready", disp_ready, e_ready);
        check("free_count", free_count, free_cnt());
        check("empty", empty, free_cnt() == BS);
        if (e_enough) begin
            for (int s = 0; s < DS; s++) begin
                check($sformatf("brtag[%0d]", s), disp_brtag[s], e_tag[s]);
                check($sformatf("brmask[%0d]", s), disp_brmask[s], e_mask[s]);
            end
        end
    endtask

    task automatic update_model();
        bit nv [BS];
        compute_expect();
        for (int t = 0; t < BS; t++) nv[t] = m_valid[t];
        if (cmt_commit)
            for (int s = 0; s < DS; s++) if (cmt_is_br[s]) nv[cmt_brtag[s]] = 0;
        if (upd && !dead) begin
            if (misp)
                for (int t = 0; t < BS; t++)
                    if (m_valid[t] && m_seq[t] > m_seq[upd_tag]) nv[t] = 0;
            m_res[upd_tag] = 1;
        end
        if (disp_valid && e_ready)
            for (int s = 0; s < DS; s++)
                if (disp_is_br[s]) begin
                    nv[e_tag[s]] = 1; m_res[e_tag[s]] = 0; m_seq[e_tag[s]] = seq_ctr++;
                end
        if (flush) for (int t = 0; t < BS; t++) nv[t] = 0;
        for (int t = 0; t < BS; t++) m_valid[t] = nv[t];
    endtask

    task automatic idle();
        disp_valid = 0; disp_is_br = '0;
        cmt_commit = 0; cmt_is_br = '0; cmt_brtag = '0;
        upd = 0; misp = 0; dead = 0; upd_tag = '0; flush = 0;
    endtask

    task automatic settle();
        #1;
        compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic dispatch(input logic [DS-1:0] br);
        idle(); disp_valid = 1; disp_is_br = br; settle(); tick();
    endtask

    task automatic gen_random();
        int q[$];
        int n, s;
        idle();
        disp_valid = ($urandom_range(0, 3) != 0);
        disp_is_br = DS'($urandom);
        if ($urandom_range(0, 2) == 0) begin
            for (int t = 0; t < BS; t++) if (m_valid[t] && !m_res[t]) q.push_back(t);
            if (q.size() > 0) begin
                upd = 1; upd_tag = TW'(q[$urandom_range(0, q.size() - 1)]);
                misp = ($urandom_range(0, 7) == 0);
                dead = ($urandom_range(0, 7) == 0);
            end
        end else if ($urandom_range(0, 9) == 0) begin
            upd = 1; dead = 1; misp = $urandom_range(0, 1); upd_tag = TW'($urandom);
        end
        q.delete();
        if ($urandom_range(0, 1) == 1) begin
            for (int t = 0; t < BS; t++) if (m_valid[t] && m_res[t]) q.push_back(t);
            n = $urandom_range(1, DS);
            s = 0;
            for (int i = 0; i < q.size() && s < n; i++) begin
                cmt_is_br[s] = 1'b1; cmt_brtag[s] = TW'(q[i]); s++;
            end
            for (int k = s; k < DS; k++) cmt_brtag[k] = TW'($urandom);
            cmt_commit = (s > 0);
        end
        flush = ($urandom_range(0, 49) == 0);
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        settle();
        check("reset free_count", free_count, 16);
        check("reset empty", empty, 1);
        check("reset ready", disp_ready, 1);

        // Four branches from empty: tags 0..3, slot3 depends on 0..2.
        disp_valid = 1; disp_is_br = 4'b1111;
        settle();
        check("t1 ready", disp_ready, 1);
        for (int s = 0; s < DS; s++) check("t1 brtag", disp_brtag[s], s);
        check("t1 brmask3", disp_brmask[3], 16'h0007);
        check("t1 brmask1", disp_brmask[1], 16'h0001);
        tick();
        idle(); settle();
        check("t1 free_count", free_count, 12);

        // Mispredict tag1 frees 2 and 3, blocks dispatch that cycle.
        upd = 1; misp = 1; upd_tag = 1; disp_valid = 1; disp_is_br = 4'b0001;
        settle();
        check("t3 ready", disp_ready, 0);
        tick();
        idle(); settle();
        check("t3 free_count", free_count, 14);

        // Tag0 resolves correct: leaves the live mask but stays allocated.
        upd = 1; upd_tag = 0; settle(); tick();
        idle(); disp_valid = 1; disp_is_br = 4'b0001; settle();
        check("t4 brtag", disp_brtag[0], 2);
        check("t4 brmask", disp_brmask[0], 16'h0000);
        check("t4 free_count", free_count, 14);
        tick();

        // Fill all tags, then commit tag 5 and reuse it.
        idle(); flush = 1; settle(); tick();
        repeat (4) dispatch(4'b1111);
        idle(); disp_valid = 1; disp_is_br = 4'b0001; settle();
        check("t2 full free_count", free_count, 0);
        check("t2 full ready", disp_ready, 0);
        tick();
        idle(); cmt_commit = 1; cmt_is_br = 4'b0001; cmt_brtag[0] = 5; settle(); tick();
        idle(); disp_valid = 1; disp_is_br = 4'b0001; settle();
        check("t2 ready", disp_ready, 1);
        check("t2 brtag", disp_brtag[0], 5);
        tick();

        // Commit and dispatch in the same cycle while full: freed tag waits a cycle.
        idle(); cmt_commit = 1; cmt_is_br = 4'b0001; cmt_brtag[0] = 0;
        disp_valid = 1; disp_is_br = 4'b0001; settle();
        check("t5 ready", disp_ready, 0);
        tick();
        idle(); disp_valid = 1; disp_is_br = 4'b0001; settle();
        check("t5 ready next", disp_ready, 1);
        check("t5 brtag", disp_brtag[0], 0);
        tick();

        // Flush with ten live tags beats a same-cycle dispatch.
        idle(); flush = 1; settle(); tick();
        dispatch(4'b1111); dispatch(4'b1111); dispatch(4'b0011);
        idle(); flush = 1; disp_valid = 1; disp_is_br = 4'b0001; settle();
        check("t6 free_count before", free_count, 6);
        check("t6 ready", disp_ready, 0);
        tick();
        idle(); settle();
        check("t6 free_count", free_count, 16);

        for (int i = 0; i < 3000; i++) begin
            gen_random();
            settle();
            if (i == 1500) begin
                // Asynchronous reset in the middle of a busy cycle.
                #2 rst = 1;
                #1 idle();
                #1;
                check("mid reset free_count", free_count, 16);
                check("mid reset empty", empty, 1);
                check("mid reset ready", disp_ready, 1);
                check("mid reset brtag", disp_brtag, 0);
                check("mid reset brmask0", disp_brmask[0], 0);
                check("mid reset brmask3", disp_brmask[3], 0);
                model_reset();
                @(negedge clk);
                rst = 0;
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
